// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy level, almost/full/empty flags, sticky
// overflow/underflow errors and a selectable standard or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATA_LEN            = 16,
  parameter int FIFO_DEPTH          = 512,
  parameter int ALMOST_FULL_THRESH  = 448,
  parameter int ALMOST_EMPTY_THRESH = 64,
  parameter int FWFT                = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_en,
  input  logic [DATA_LEN-1:0]         data_in,
  input  logic                        read_en,
  output logic [DATA_LEN-1:0]         data_out,
  output logic                        data_valid,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flags: FIFO_DEPTH must be a power of two and >= 4");
  end
  if ((ALMOST_FULL_THRESH < 1) || (ALMOST_FULL_THRESH > FIFO_DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: ALMOST_FULL_THRESH out of range");
  end
  if ((ALMOST_EMPTY_THRESH < 0) || (ALMOST_EMPTY_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flags: ALMOST_EMPTY_THRESH out of range");
  end

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                full_q, empty_q, afull_q, aempty_q;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_LEN-1:0] dout_q;
  logic                dvalid_q;
  logic                wr_acc, rd_acc;

  always_comb begin
    wr_acc   = write_en && !full_q;
    rd_acc   = read_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc) level_d = level_q + LVL_ONE;
    if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
    // A new error event outranks a coincident clear.
    ovf_d = (write_en && full_q) || (ovf_q && !clear_err);
    udf_d = (read_en && empty_q) || (udf_q && !clear_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LW'(FIFO_DEPTH));
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= LW'(ALMOST_FULL_THRESH));
      aempty_q <= (level_d <= LW'(ALMOST_EMPTY_THRESH));
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dvalid_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  // FWFT presents the head word directly; the empty gate keeps stale storage off the port.
  if (FWFT != 0) begin : g_fwft
    assign data_out   = empty_q ? '0 : mem[rd_ptr_q];
    assign data_valid = !empty_q;
  end else begin : g_std
    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
  end

  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: standard and FWFT instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DL    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [DL-1:0] din = '0;

  logic [DL-1:0] s_dout, f_dout;
  logic          s_val, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_val, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [3:0]    s_lvl, f_lvl;

  sync_fifo_flags #(.DATA_LEN(DL), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESH(AF),
                    .ALMOST_EMPTY_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .write_en(we), .data_in(din), .read_en(re),
    .data_out(s_dout), .data_valid(s_val), .fifo_full(s_full), .fifo_empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_lvl), .overflow(s_ovf),
    .underflow(s_udf), .clear_err(clr));

  sync_fifo_flags #(.DATA_LEN(DL), .FIFO_DEPTH(DEPTH), .ALMOST_FULL_THRESH(AF),
                    .ALMOST_EMPTY_THRESH(AE), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .write_en(we), .data_in(din), .read_en(re),
    .data_out(f_dout), .data_valid(f_val), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_lvl), .overflow(f_ovf),
    .underflow(f_udf), .clear_err(clr));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DL-1:0] mq[$];
  bit            m_ovf, m_udf, m_val;
  logic [DL-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 0;
    m_udf  = 0;
    m_val  = 0;
    m_dout = '0;
  endtask

  task automatic model_edge();
    bit full, empty;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_val = 0;
    if (re && !empty) begin
      m_dout = mq.pop_front();
      m_val  = 1;
    end
    if (we && !full) mq.push_back(din);
    m_ovf = (we && full) || (m_ovf && !clr);
    m_udf = (re && empty) || (m_udf && !clr);
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("std_level", 32'(s_lvl), 32'(n));
    chk("std_full", 32'(s_full), 32'(n == DEPTH));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_afull", 32'(s_af), 32'(n >= AF));
    chk("std_aempty", 32'(s_ae), 32'(n <= AE));
    chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
    chk("std_udf", 32'(s_udf), 32'(m_udf));
    chk("std_valid", 32'(s_val), 32'(m_val));
    chk("std_dout", 32'(s_dout), 32'(m_dout));
    chk("fw_level", 32'(f_lvl), 32'(n));
    chk("fw_full", 32'(f_full), 32'(n == DEPTH));
    chk("fw_empty", 32'(f_empty), 32'(n == 0));
    chk("fw_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("fw_udf", 32'(f_udf), 32'(m_udf));
    chk("fw_valid", 32'(f_val), 32'(n != 0));
    if (n != 0) chk("fw_dout", 32'(f_dout), 32'(mq[0]));
  endtask

  task automatic step(input logic w, input logic [DL-1:0] d, input logic r, input logic c);
    we  = w;
    din = d;
    re  = r;
    clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_literals();
    chk("rst_level", 32'(s_lvl), 32'h0);
    chk("rst_empty", 32'(s_empty), 32'h1);
    chk("rst_aempty", 32'(s_ae), 32'h1);
    chk("rst_full", 32'(s_full), 32'h0);
    chk("rst_afull", 32'(s_af), 32'h0);
    chk("rst_dout", 32'(s_dout), 32'h0);
    chk("rst_valid", 32'(s_val), 32'h0);
    chk("rst_ovf", 32'(s_ovf), 32'h0);
    chk("rst_udf", 32'(s_udf), 32'h0);
    chk("rst_fw_dout", 32'(f_dout), 32'h0);
    chk("rst_fw_valid", 32'(f_val), 32'h0);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_literals();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Three writes: level tracks, empty then almost_empty fall.
    step(1, 16'h0001, 0, 0);
    chk("lit_lvl1", 32'(s_lvl), 32'd1);
    chk("lit_empty_drop", 32'(s_empty), 32'h0);
    step(1, 16'h0002, 0, 0);
    chk("lit_ae_at2", 32'(s_ae), 32'h1);
    step(1, 16'h0003, 0, 0);
    chk("lit_lvl3", 32'(s_lvl), 32'd3);
    chk("lit_ae_at3", 32'(s_ae), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(0, '0, 1, 0);
      chk("lit_drain3", 32'(s_dout), 32'(i));
    end

    // Fill, overflow attempt, then drain with idle gaps between reads.
    for (int i = 0; i < 8; i++) step(1, 16'(16'h0010 + i), 0, 0);
    step(1, 16'hDEAD, 0, 0);
    chk("lit_full", 32'(s_full), 32'h1);
    chk("lit_afull", 32'(s_af), 32'h1);
    chk("lit_ovf", 32'(s_ovf), 32'h1);
    chk("lit_lvl8", 32'(s_lvl), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0);
      chk("lit_drain_data", 32'(s_dout), 32'(16'h0010 + i));
      chk("lit_drain_valid", 32'(s_val), 32'h1);
      step(0, '0, 0, 0);
      chk("lit_valid_pulse", 32'(s_val), 32'h0);
    end

    // Underflow, clear, and set-wins-over-clear.
    step(0, '0, 1, 0);
    chk("lit_udf", 32'(s_udf), 32'h1);
    chk("lit_udf_valid", 32'(s_val), 32'h0);
    step(0, '0, 0, 1);
    chk("lit_udf_clr", 32'(s_udf), 32'h0);
    chk("lit_ovf_clr", 32'(s_ovf), 32'h0);
    step(0, '0, 1, 1);
    chk("lit_udf_setwins", 32'(s_udf), 32'h1);

    // Level 4 with simultaneous traffic wraps pointers.
    for (int i = 0; i < 4; i++) step(1, 16'(16'h0100 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 16'($urandom), 1, 0);
      chk("lit_lvl_hold4", 32'(s_lvl), 32'd4);
    end
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // FWFT fall-through and pop.
    step(1, 16'hA5A5, 0, 0);
    chk("lit_fw_dout", 32'(f_dout), 32'hA5A5);
    chk("lit_fw_valid", 32'(f_val), 32'h1);
    step(0, '0, 1, 0);
    chk("lit_fw_valid_pop", 32'(f_val), 32'h0);
    chk("lit_fw_empty_pop", 32'(f_empty), 32'h1);

    // Randomised traffic: write-heavy, balanced, then read-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < (75 - 25 * ph), 16'($urandom),
             $urandom_range(0, 99) < (25 + 25 * ph), $urandom_range(0, 99) < 5);
      end
    end

    // Asynchronous reset mid-burst.
    step(0, '0, 0, 1);
    while (mq.size() != 0) step(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 16'(16'h0200 + i), 0, 0);
    we    = 1'b1;
    din   = 16'h0BAD;
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_reset_literals();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    step(1, 16'h0042, 0, 0);
    chk("lit_post_rst_fw", 32'(f_dout), 32'h0042);
    step(0, '0, 1, 0);
    chk("lit_post_rst_dout", 32'(s_dout), 32'h0042);
    chk("lit_post_rst_valid", 32'(s_val), 32'h1);
    step(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parameterised single-clock FIFO that replaces the hard-wired 16-bit buffer in the Ethernet-to-UART data path.
- Adds proper occupancy tracking, full/empty protection, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
- Sits between a bursty producer and a slower consumer on the same clock; back-pressure comes from the flags.

Parameters:
- DATA_LEN, 16, data word width in bits (>=1).
- FIFO_DEPTH, 512, number of words; power of two, >=4.
- ALMOST_FULL_THRESH, 448, almost_full asserts when level >= this value (1..FIFO_DEPTH).
- ALMOST_EMPTY_THRESH, 64, almost_empty asserts when level <= this value (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_en  in  1  write request.
- data_in  in  DATA_LEN  write data.
- read_en  in  1  read request (in FWFT mode, this is the pop/acknowledge).
- data_out  out  DATA_LEN  read data.
- data_valid  out  1  data_out holds a valid word.
- fifo_full  out  1  level == FIFO_DEPTH.
- fifo_empty  out  1  level == 0.
- almost_full  out  1  level >= ALMOST_FULL_THRESH.
- almost_empty  out  1  level <= ALMOST_EMPTY_THRESH.
- level  out  $clog2(FIFO_DEPTH)+1  current word count.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clear_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and level = 0.
  - fifo_empty = 1, almost_empty = 1.
  - fifo_full = 0, almost_full = 0.
  - data_out = 0, data_valid = 0.
  - overflow = 0, underflow = 0.
  - Storage array is not reset.
  - A reset asserted mid-transfer discards all contents; the first accepted write after release lands at address 0.
- Acceptance:
  - Write accepted iff write_en && !fifo_full.
  - Read accepted iff read_en && !fifo_empty.
  - Decisions use the registered flags only; no combinational full/empty bypass.
- Pointers: $clog2(FIFO_DEPTH) bits; advance by 1 per accepted operation; wrap FIFO_DEPTH-1 -> 0 with no gap.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
  - All four flags derive from the registered level and update the cycle after the accepting edge.
- Simultaneous write and read:
  - Not full and not empty: both accepted, level unchanged.
  - When empty: write accepted, read rejected (underflow sets).
  - When full: read accepted, write rejected (overflow sets).
- Standard mode (FWFT=0):
  - data_out registers mem[rd_ptr] on the edge that accepts a read; latency is 1 cycle.
  - data_valid is high for exactly the cycle after each accepted read.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; data_valid = !fifo_empty.
  - A word written into an empty FIFO appears at data_out 1 cycle after the write edge.
  - An accepted read_en advances to the next word on the following cycle.
- Error flags:
  - overflow sets on any cycle with write_en && fifo_full.
  - underflow sets on any cycle with read_en && fifo_empty.
  - Both are sticky until clear_err.
  - If clear_err coincides with a new error event, set wins.
  - Rejected operations change neither storage nor pointers.
- Elaboration error if:
  - FIFO_DEPTH is not a power of two or is <4, or
  - either threshold is outside its range.

Test Plan (DATA_LEN=16, FIFO_DEPTH=8, ALMOST_FULL_THRESH=6, ALMOST_EMPTY_THRESH=2):
- Reset, then write 0x0001..0x0003 on consecutive cycles -> level 1,2,3 one cycle after each write; fifo_empty drops after the first write; almost_empty drops when level=3.
- Fill to 8 words 0x0010..0x0017, then write 0xDEAD while full -> fifo_full=1, almost_full=1, overflow=1, level stays 8; drain 8 reads -> data_out 0x0010..0x0017 in order, each with a 1-cycle data_valid pulse, 0xDEAD never appears.
- Empty FIFO, assert read_en -> underflow=1, data_valid stays 0; pulse clear_err -> underflow=0; clear_err together with read_en while empty -> underflow stays 1.
- Hold level 4, assert write_en and read_en together for 20 cycles -> level stays 4, pointers wrap past 7->0, output order matches input order.
- FWFT=1: write 0xA5A5 into empty -> next cycle data_out=0xA5A5, data_valid=1; assert read_en -> next cycle data_valid=0, fifo_empty=1.
- Write 5 words, assert rst_n=0 mid-burst -> all outputs return to reset values immediately; after release, write 0x0042 then read -> data_out=0x0042.
